imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 94 +++++++++
 tb/tb_imem_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, IMEM write port and boot status of the loader.
interface imem_loader_if #(
   parameter int AW = 10
);
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst_n;
   logic          done;
   logic          err;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, err
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Receives a framed byte stream, writes it word by word into IMEM, and
// releases the core from reset only after a length- and checksum-valid load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         AW        = 10,
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
   input logic          clk,
   input logic          rst,
   imem_loader_if.slave bus
);

   state_t        state, state_n;
   logic [15:0]   word_cnt;
   logic [1:0]    byte_cnt;
   logic [23:0]   shreg;
   logic [7:0]    csum;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;

   logic          ready;
   logic          acc;
   logic [15:0]   len_n;
   logic          len_too_big;

   assign ready = (state != S_DONE) && (state != S_ERR);
   assign acc   = bus.rx_valid && ready;
   // LEN_LO is parked in the low byte of the word counter until LEN_HI arrives
   assign len_n       = {bus.rx_data, word_cnt[7:0]};
   assign len_too_big = ({16'h0, len_n} > (32'd1 << AW));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_SYNC;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_SYNC:   if (acc && bus.rx_data == SYNC_BYTE) state_n = S_LEN_LO;
         S_LEN_LO: if (acc) state_n = S_LEN_HI;
         S_LEN_HI: if (acc) begin
            if (len_too_big)       state_n = S_ERR;
            else if (len_n == '0)  state_n = S_CHK;
            else                   state_n = S_DATA;
         end
         S_DATA:   if (acc && byte_cnt == 2'd3 && word_cnt == 16'd1) state_n = S_CHK;
         S_CHK:    if (acc) state_n = (bus.rx_data == csum) ? S_DONE : S_ERR;
         default:  state_n = state;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
         byte_cnt <= '0;
         shreg    <= '0;
         csum     <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         we_q <= 1'b0;
         // address advances after the strobe so it holds the word index during it
         if (we_q) addr_q <= addr_q + AW'(1);
         case (state)
            S_LEN_LO: if (acc) word_cnt <= {8'h00, bus.rx_data};
            S_LEN_HI: if (acc) word_cnt <= len_n;
            S_DATA: if (acc) begin
               csum     <= csum ^ bus.rx_data;
               byte_cnt <= byte_cnt + 2'd1;
               shreg    <= {bus.rx_data, shreg[23:8]};
               if (byte_cnt == 2'd3) begin
                  we_q     <= 1'b1;
                  wdata_q  <= {bus.rx_data, shreg};
                  word_cnt <= word_cnt - 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rx_ready   = ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.done       = (state == S_DONE);
   assign bus.err        = (state == S_ERR);
   assign bus.core_rst_n = (state == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected IMEM writes queued per frame and
// checked as the strobes appear; status checked after each frame.
module tb_imem_loader;
   localparam int AW = 10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   wr_t  exp_q[$];
   logic [7:0] frm[$];

   imem_loader_if #(.AW(AW)) bus ();

   imem_loader #(.AW(AW), .SYNC_BYTE(8'hA5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every write strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_we", {54'h0, bus.imem_addr}, 64'hFFFF);
         else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {54'h0, bus.imem_addr}, {54'h0, e.addr});
            chk("wr_data", {32'h0, bus.imem_wdata}, {32'h0, e.data});
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) begin
         bus.rx_valid = 1'b0;
         @(negedge clk);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int maxgap);
      foreach (frm[i]) send(frm[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, {63'h0, bus.rx_ready},   64'h1);
      chk({tag, "_we"},    {63'h0, bus.imem_we},    64'h0);
      chk({tag, "_addr"},  {54'h0, bus.imem_addr},  64'h0);
      chk({tag, "_wdata"}, {32'h0, bus.imem_wdata}, 64'h0);
      chk({tag, "_crst"},  {63'h0, bus.core_rst_n}, 64'h0);
      chk({tag, "_done"},  {63'h0, bus.done},       64'h0);
      chk({tag, "_err"},   {63'h0, bus.err},        64'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e);
      chk({tag, "_done"},  {63'h0, bus.done},       {63'h0, d});
      chk({tag, "_err"},   {63'h0, bus.err},        {63'h0, e});
      chk({tag, "_crst"},  {63'h0, bus.core_rst_n}, {63'h0, d});
      chk({tag, "_ready"}, {63'h0, bus.rx_ready},   64'h0);
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'h0);
   endtask

   task automatic load_good_frame(input logic [7:0] ck);
      frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
              8'h93, 8'h05, 8'h10, 8'h00, ck};
      exp_q.push_back('{addr: 10'd0, data: 32'h00A00513});
      exp_q.push_back('{addr: 10'd1, data: 32'h00100593});
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      check_reset_outputs("init");
      do_reset();

      // good two-word frame, back-to-back bytes
      load_good_frame(8'h30);
      send_frame(0);
      check_status("good", 1'b1, 1'b0);

      // bad checksum
      do_reset();
      load_good_frame(8'h31);
      send_frame(0);
      check_status("badck", 1'b0, 1'b1);

      // junk before sync, empty payload
      do_reset();
      frm = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(0);
      check_status("empty", 1'b1, 1'b0);

      // length one past capacity
      do_reset();
      frm = '{8'hA5, 8'h01, 8'h04};
      send_frame(0);
      check_status("toolong", 1'b0, 1'b1);

      // reset mid-word, then a clean reload from address 0
      do_reset();
      frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
      send_frame(0);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      do_reset();
      load_good_frame(8'h30);
      send_frame(0);
      check_status("reload", 1'b1, 1'b0);

      // random valid gaps
      do_reset();
      load_good_frame(8'h30);
      send_frame(5);
      check_status("gaps", 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
